id_operand_stage: RTL and testbench

- Parametrised successor to the decode-stage operand logic. Takes decoded fields and register-file read data, and resolves operands with EX/MEM forwarding.
- Detects load-use hazards and inserts a multi-cycle bubble.
- Resolves register branches on forwarded data.
- Owns the ID/EX pipeline register, including flush and hold handling. Sits between the decoder and the EX stage.

---
 rtl/id_operand_stage_if.sv | 75 +++++++
 rtl/id_operand_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if
//   Bundles the decode-stage inputs, the EX/MEM forwarding sources, the
//   hold/flush controls and the ID/EX outputs of id_operand_stage.
//   slave  : the operand stage itself (consumes dec_*/rf_*/ex_*/mem_*,
//            drives stall/branch/ex_*_o/stall_count_o).
//   master : whatever drives the stage (decoder, pipeline control, bench).
interface id_operand_stage_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int ADDR_W  = 16,
  parameter int OP_W    = 8,
  parameter int SEL_W   = 3
);
  // decode stage
  logic               dec_valid;
  logic               dec_re0;
  logic               dec_re1;
  logic [RADDR_W-1:0] dec_addr0;
  logic [RADDR_W-1:0] dec_addr1;
  logic [DATA_W-1:0]  dec_imm0;
  logic [DATA_W-1:0]  dec_imm1;
  logic               dec_we;
  logic [RADDR_W-1:0] dec_waddr;
  logic               dec_is_load;
  logic [OP_W-1:0]    dec_aluop;
  logic [SEL_W-1:0]   dec_alusel;
  logic [1:0]         dec_br_mode;
  logic [ADDR_W-1:0]  dec_br_target;
  // register file
  logic [DATA_W-1:0]  rf_data0;
  logic [DATA_W-1:0]  rf_data1;
  // forwarding sources
  logic               ex_we;
  logic               ex_is_load;
  logic [RADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0]  ex_wdata;
  logic               mem_we;
  logic [RADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  // pipeline control
  logic               hold_i;
  logic               flush_i;
  // outputs
  logic               stall_req_o;
  logic               branch_flag_o;
  logic [ADDR_W-1:0]  branch_addr_o;
  logic [DATA_W-1:0]  ex_op0_o;
  logic [DATA_W-1:0]  ex_op1_o;
  logic               ex_we_o;
  logic [RADDR_W-1:0] ex_waddr_o;
  logic               ex_is_load_o;
  logic [OP_W-1:0]    ex_aluop_o;
  logic [SEL_W-1:0]   ex_alusel_o;
  logic [15:0]        stall_count_o;

  modport slave (
    input  dec_valid, dec_re0, dec_re1, dec_addr0, dec_addr1, dec_imm0, dec_imm1,
           dec_we, dec_waddr, dec_is_load, dec_aluop, dec_alusel, dec_br_mode,
           dec_br_target, rf_data0, rf_data1, ex_we, ex_is_load, ex_waddr,
           ex_wdata, mem_we, mem_waddr, mem_wdata, hold_i, flush_i,
    output stall_req_o, branch_flag_o, branch_addr_o, ex_op0_o, ex_op1_o,
           ex_we_o, ex_waddr_o, ex_is_load_o, ex_aluop_o, ex_alusel_o,
           stall_count_o
  );

  modport master (
    output dec_valid, dec_re0, dec_re1, dec_addr0, dec_addr1, dec_imm0, dec_imm1,
           dec_we, dec_waddr, dec_is_load, dec_aluop, dec_alusel, dec_br_mode,
           dec_br_target, rf_data0, rf_data1, ex_we, ex_is_load, ex_waddr,
           ex_wdata, mem_we, mem_waddr, mem_wdata, hold_i, flush_i,
    input  stall_req_o, branch_flag_o, branch_addr_o, ex_op0_o, ex_op1_o,
           ex_we_o, ex_waddr_o, ex_is_load_o, ex_aluop_o, ex_alusel_o,
           stall_count_o
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage
//   Decode-stage operand resolution and ID/EX pipeline register.
//   - Resolves both operands from immediate / EX forward / MEM forward / RF.
//   - Detects load-use hazards against the EX stage and stalls IF/ID for
//     LOAD_LAT cycles, feeding bubbles into EX meanwhile.
//   - Resolves register branches combinationally on forwarded op0.
//   - Counts load-use stall cycles (saturating, cleared only by reset).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_operand_stage_if.slave (decode fields, RF data,
//              forwarding sources, hold/flush, ID/EX outputs)
module id_operand_stage #(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int ADDR_W   = 16,
  parameter int OP_W     = 8,
  parameter int SEL_W    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  id_operand_stage_if.slave     bus
);

  typedef enum logic {RUN, LSTALL} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_next;

  logic [DATA_W-1:0]  w_op0;
  logic [DATA_W-1:0]  w_op1;
  logic               w_hazard;
  logic               w_stall_req;
  logic               w_br_cond;
  logic               w_br_taken;

  logic [DATA_W-1:0]  r_op0;
  logic [DATA_W-1:0]  r_op1;
  logic               r_we;
  logic [RADDR_W-1:0] r_waddr;
  logic               r_is_load;
  logic [OP_W-1:0]    r_aluop;
  logic [SEL_W-1:0]   r_alusel;
  logic [15:0]        r_stall_count;

  // EX forwarding skips loads: their data is not ready until MEM, which is
  // exactly the case the load-use stall covers.
  function automatic logic [DATA_W-1:0] resolve_operand(
    input logic               re,
    input logic [RADDR_W-1:0] addr,
    input logic [DATA_W-1:0]  imm,
    input logic [DATA_W-1:0]  rf_data
  );
    if (!re)
      return imm;
    else if (bus.ex_we && !bus.ex_is_load && (bus.ex_waddr == addr))
      return bus.ex_wdata;
    else if (bus.mem_we && (bus.mem_waddr == addr))
      return bus.mem_wdata;
    else
      return rf_data;
  endfunction

  always_comb begin
    w_op0 = resolve_operand(bus.dec_re0, bus.dec_addr0, bus.dec_imm0, bus.rf_data0);
    w_op1 = resolve_operand(bus.dec_re1, bus.dec_addr1, bus.dec_imm1, bus.rf_data1);
  end

  assign w_hazard = bus.dec_valid && bus.ex_we && bus.ex_is_load &&
                    ((bus.dec_re0 && (bus.dec_addr0 == bus.ex_waddr)) ||
                     (bus.dec_re1 && (bus.dec_addr1 == bus.ex_waddr)));

  // RUN contributes the first stall cycle; LSTALL the remaining LOAD_LAT-1.
  assign w_stall_req = ((r_state == RUN) && w_hazard) ||
                       ((r_state == LSTALL) && (r_cnt != 3'd0));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (bus.flush_i) begin
      w_state_next = RUN;
      w_cnt_next   = 3'd0;
    end else if (!bus.hold_i) begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            w_state_next = LSTALL;
            w_cnt_next   = 3'(LOAD_LAT - 1);
          end
        end
        LSTALL: begin
          if (r_cnt == 3'd0)
            w_state_next = RUN;
          else
            w_cnt_next = r_cnt - 3'd1;
        end
        default: begin
          w_state_next = RUN;
          w_cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // ID/EX pipeline register: rst > flush > hold > stall > normal
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      r_op0     <= '0;
      r_op1     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_is_load <= 1'b0;
      r_aluop   <= '0;
      r_alusel  <= '0;
    end else if (!bus.hold_i) begin
      if (w_stall_req || !bus.dec_valid) begin
        r_op0     <= '0;
        r_op1     <= '0;
        r_we      <= 1'b0;
        r_waddr   <= '0;
        r_is_load <= 1'b0;
        r_aluop   <= '0;
        r_alusel  <= '0;
      end else begin
        r_op0     <= w_op0;
        r_op1     <= w_op1;
        r_we      <= bus.dec_we;
        r_waddr   <= bus.dec_waddr;
        r_is_load <= bus.dec_is_load;
        r_aluop   <= bus.dec_aluop;
        r_alusel  <= bus.dec_alusel;
      end
    end
  end

  // Stall-cycle counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_count <= 16'd0;
    else if (!bus.hold_i && w_stall_req && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end

  // Branch resolution on forwarded op0; suppressed while stalled so a
  // branch on a just-loaded register waits for valid data.
  always_comb begin
    w_br_cond = 1'b0;
    case (bus.dec_br_mode)
      2'b01:   w_br_cond = 1'b1;
      2'b10:   w_br_cond = (w_op0 == '0);
      2'b11:   w_br_cond = (w_op0 != '0);
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_br_taken = bus.dec_valid && !w_stall_req && !bus.hold_i &&
                      !bus.flush_i && w_br_cond;

  assign bus.stall_req_o   = w_stall_req;
  assign bus.branch_flag_o = w_br_taken;
  assign bus.branch_addr_o = w_br_taken ? bus.dec_br_target : '0;
  assign bus.ex_op0_o      = r_op0;
  assign bus.ex_op1_o      = r_op1;
  assign bus.ex_we_o       = r_we;
  assign bus.ex_waddr_o    = r_waddr;
  assign bus.ex_is_load_o  = r_is_load;
  assign bus.ex_aluop_o    = r_aluop;
  assign bus.ex_alusel_o   = r_alusel;
  assign bus.stall_count_o = r_stall_count;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage
//   Three instances with LOAD_LAT = 1, 2, 3 share one set of stimulus;
//   each instance's outputs are checked against hand-computed values.
module tb_id_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus
  logic        dec_valid, dec_re0, dec_re1, dec_we, dec_is_load;
  logic [3:0]  dec_addr0, dec_addr1, dec_waddr;
  logic [15:0] dec_imm0, dec_imm1, dec_br_target;
  logic [7:0]  dec_aluop;
  logic [2:0]  dec_alusel;
  logic [1:0]  dec_br_mode;
  logic [15:0] rf_data0, rf_data1;
  logic        ex_we, ex_is_load, mem_we;
  logic [3:0]  ex_waddr, mem_waddr;
  logic [15:0] ex_wdata, mem_wdata;
  logic        hold_i, flush_i;

  // per-instance outputs (index k has LOAD_LAT = k+1)
  logic        stall_o[3];
  logic        brf_o[3];
  logic [15:0] bra_o[3];
  logic [15:0] op0_o[3];
  logic [15:0] op1_o[3];
  logic        we_o[3];
  logic [3:0]  waddr_o[3];
  logic        isld_o[3];
  logic [7:0]  aluop_o[3];
  logic [2:0]  alusel_o[3];
  logic [15:0] cnt_o[3];

  id_operand_stage_if bus[3] ();

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      assign bus[gi].dec_valid     = dec_valid;
      assign bus[gi].dec_re0       = dec_re0;
      assign bus[gi].dec_re1       = dec_re1;
      assign bus[gi].dec_addr0     = dec_addr0;
      assign bus[gi].dec_addr1     = dec_addr1;
      assign bus[gi].dec_imm0      = dec_imm0;
      assign bus[gi].dec_imm1      = dec_imm1;
      assign bus[gi].dec_we        = dec_we;
      assign bus[gi].dec_waddr     = dec_waddr;
      assign bus[gi].dec_is_load   = dec_is_load;
      assign bus[gi].dec_aluop     = dec_aluop;
      assign bus[gi].dec_alusel    = dec_alusel;
      assign bus[gi].dec_br_mode   = dec_br_mode;
      assign bus[gi].dec_br_target = dec_br_target;
      assign bus[gi].rf_data0      = rf_data0;
      assign bus[gi].rf_data1      = rf_data1;
      assign bus[gi].ex_we         = ex_we;
      assign bus[gi].ex_is_load    = ex_is_load;
      assign bus[gi].ex_waddr      = ex_waddr;
      assign bus[gi].ex_wdata      = ex_wdata;
      assign bus[gi].mem_we        = mem_we;
      assign bus[gi].mem_waddr     = mem_waddr;
      assign bus[gi].mem_wdata     = mem_wdata;
      assign bus[gi].hold_i        = hold_i;
      assign bus[gi].flush_i       = flush_i;

      assign stall_o[gi]  = bus[gi].stall_req_o;
      assign brf_o[gi]    = bus[gi].branch_flag_o;
      assign bra_o[gi]    = bus[gi].branch_addr_o;
      assign op0_o[gi]    = bus[gi].ex_op0_o;
      assign op1_o[gi]    = bus[gi].ex_op1_o;
      assign we_o[gi]     = bus[gi].ex_we_o;
      assign waddr_o[gi]  = bus[gi].ex_waddr_o;
      assign isld_o[gi]   = bus[gi].ex_is_load_o;
      assign aluop_o[gi]  = bus[gi].ex_aluop_o;
      assign alusel_o[gi] = bus[gi].ex_alusel_o;
      assign cnt_o[gi]    = bus[gi].stall_count_o;

      id_operand_stage #(.LOAD_LAT(gi + 1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 0; dec_re0 = 0; dec_re1 = 0; dec_we = 0; dec_is_load = 0;
    dec_addr0 = 0; dec_addr1 = 0; dec_waddr = 0;
    dec_imm0 = 0; dec_imm1 = 0; dec_br_target = 0;
    dec_aluop = 0; dec_alusel = 0; dec_br_mode = 0;
    rf_data0 = 0; rf_data1 = 0;
    ex_we = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    hold_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // R2 <- load in EX; ID computes R2 + R1
  task automatic set_load_use();
    dec_valid = 1; dec_re0 = 1; dec_addr0 = 4'd2; dec_re1 = 1; dec_addr1 = 4'd1;
    rf_data0 = 16'hDEAD; rf_data1 = 16'h0010;
    dec_we = 1; dec_waddr = 4'd6; dec_aluop = 8'h01; dec_alusel = 3'd1;
    ex_we = 1; ex_is_load = 1; ex_waddr = 4'd2; ex_wdata = 16'hFFFF;
  endtask

  initial begin
    rst = 1;
    clear_inputs();

    // ---- reset state
    do_reset();
    for (int k = 0; k < 3; k++) begin
      $display("reset check lat=%0d", k + 1);
      check_val($sformatf("rst_we%0d", k), 32'(we_o[k]), 0);
      check_val($sformatf("rst_op0_%0d", k), 32'(op0_o[k]), 0);
      check_val($sformatf("rst_stall%0d", k), 32'(stall_o[k]), 0);
      check_val($sformatf("rst_cnt%0d", k), 32'(cnt_o[k]), 0);
    end

    // ---- forwarding: EX beats MEM
    dec_valid = 1; dec_re0 = 1; dec_addr0 = 4'd3; dec_re1 = 0; dec_imm1 = 16'h0077;
    rf_data0 = 16'h0BAD; dec_we = 1; dec_waddr = 4'd5; dec_aluop = 8'h21; dec_alusel = 3'd2;
    ex_we = 1; ex_waddr = 4'd3; ex_wdata = 16'h1234;
    mem_we = 1; mem_waddr = 4'd3; mem_wdata = 16'h5555;
    tick();
    $display("fwd EX+MEM hit: op0=%h op1=%h", op0_o[0], op1_o[0]);
    check_val("fwd_ex", 32'(op0_o[0]), 32'h1234);
    check_val("fwd_imm1", 32'(op1_o[0]), 32'h0077);
    check_val("fwd_we", 32'(we_o[0]), 1);
    check_val("fwd_waddr", 32'(waddr_o[0]), 5);
    check_val("fwd_aluop", 32'(aluop_o[0]), 32'h21);
    check_val("fwd_alusel", 32'(alusel_o[0]), 2);
    check_val("fwd_isld", 32'(isld_o[0]), 0);
    ex_we = 0;
    tick();
    $display("fwd MEM only: op0=%h", op0_o[2]);
    check_val("fwd_mem", 32'(op0_o[2]), 32'h5555);
    mem_we = 0;
    tick();
    $display("fwd none: op0=%h", op0_o[1]);
    check_val("fwd_rf", 32'(op0_o[1]), 32'h0BAD);
    // re0=0 with a matching EX load: immediate, no hazard
    dec_re0 = 0; dec_imm0 = 16'h0099; ex_we = 1; ex_is_load = 1; ex_waddr = 4'd3;
    #1;
    check_val("imm_nohaz", 32'(stall_o[0]), 0);
    tick();
    $display("imm with addr match: op0=%h", op0_o[0]);
    check_val("imm_op0", 32'(op0_o[0]), 32'h0099);

    // ---- load-use for LOAD_LAT = 1,2,3 in parallel
    do_reset();
    set_load_use();
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int k = 0; k < 3; k++)
        check_val($sformatf("lu_stall_c%0d_l%0d", i, k + 1), 32'(stall_o[k]), 32'(i < k + 1));
      tick();
      // load has moved on to MEM: EX now holds a bubble
      ex_we = 0; ex_is_load = 0;
      mem_we = 1; mem_waddr = 4'd2; mem_wdata = 16'h00AB;
      for (int k = 0; k < 3; k++) begin
        $display("load-use cycle %0d lat=%0d we=%0d op0=%h", i, k + 1, we_o[k], op0_o[k]);
        check_val($sformatf("lu_we_c%0d_l%0d", i, k + 1), 32'(we_o[k]), 32'(i >= k + 1));
        if (i >= k + 1) begin
          check_val($sformatf("lu_op0_c%0d_l%0d", i, k + 1), 32'(op0_o[k]), 32'h00AB);
          check_val($sformatf("lu_op1_c%0d_l%0d", i, k + 1), 32'(op1_o[k]), 32'h0010);
        end
      end
    end
    for (int k = 0; k < 3; k++)
      check_val($sformatf("lu_cnt_l%0d", k + 1), 32'(cnt_o[k]), 32'(k + 1));

    // ---- branch on MEM-forwarded R4
    do_reset();
    dec_valid = 1; dec_re0 = 1; dec_addr0 = 4'd4; rf_data0 = 16'h0007;
    mem_we = 1; mem_waddr = 4'd4; mem_wdata = 16'h0000;
    dec_br_target = 16'h0040; dec_br_mode = 2'b10;
    #1;
    $display("BEQZ: flag=%0d addr=%h", brf_o[0], bra_o[0]);
    check_val("beqz_flag", 32'(brf_o[0]), 1);
    check_val("beqz_addr", 32'(bra_o[0]), 32'h0040);
    dec_br_mode = 2'b11;
    #1;
    $display("BNEZ: flag=%0d addr=%h", brf_o[0], bra_o[0]);
    check_val("bnez_flag", 32'(brf_o[0]), 0);
    check_val("bnez_addr", 32'(bra_o[0]), 0);
    dec_br_mode = 2'b00;
    #1;
    check_val("bnone_flag", 32'(brf_o[1]), 0);
    dec_br_mode = 2'b01; hold_i = 1;
    #1;
    $display("JMP under hold: flag=%0d", brf_o[1]);
    check_val("bhold_flag", 32'(brf_o[1]), 0);
    hold_i = 0; ex_we = 1; ex_is_load = 1; ex_waddr = 4'd4;
    #1;
    $display("JMP on loading reg: flag=%0d stall=%0d", brf_o[2], stall_o[2]);
    check_val("bstall_flag", 32'(brf_o[2]), 0);
    check_val("bstall_addr", 32'(bra_o[2]), 0);

    // ---- hold mid-LSTALL, then flush
    do_reset();
    set_load_use();
    tick();  // hazard cycle: all enter LSTALL, count=1
    ex_we = 0; ex_is_load = 0;
    hold_i = 1;
    for (int h = 0; h < 2; h++) begin
      tick();
      $display("hold %0d: lat3 stall=%0d cnt=%0d we=%0d", h, stall_o[2], cnt_o[2], we_o[2]);
      check_val($sformatf("hold_cnt_%0d", h), 32'(cnt_o[2]), 1);
      check_val($sformatf("hold_stall_%0d", h), 32'(stall_o[2]), 1);
      check_val($sformatf("hold_we_%0d", h), 32'(we_o[2]), 0);
      check_val($sformatf("hold_l1_stall_%0d", h), 32'(stall_o[0]), 0);
      check_val($sformatf("hold_l1_we_%0d", h), 32'(we_o[0]), 0);
    end
    hold_i = 0;
    tick();
    $display("after hold: lat3 cnt=%0d stall=%0d", cnt_o[2], stall_o[2]);
    check_val("post_hold_cnt", 32'(cnt_o[2]), 2);
    check_val("post_hold_stall", 32'(stall_o[2]), 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    #1;
    $display("after flush: lat3 stall=%0d we=%0d cnt=%0d", stall_o[2], we_o[2], cnt_o[2]);
    check_val("flush_stall", 32'(stall_o[2]), 0);
    check_val("flush_we", 32'(we_o[2]), 0);
    check_val("flush_op0", 32'(op0_o[2]), 0);
    check_val("flush_cnt_kept", 32'(cnt_o[2] != 16'd0), 1);
    tick();
    check_val("flush_issue_we", 32'(we_o[2]), 1);

    // ---- reset during LSTALL, LOAD_LAT = 2
    do_reset();
    set_load_use();
    tick();
    ex_we = 0; ex_is_load = 0;
    check_val("rst_lstall_pre", 32'(stall_o[1]), 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    $display("rst in LSTALL: stall=%0d we=%0d cnt=%0d", stall_o[1], we_o[1], cnt_o[1]);
    check_val("rstl_stall", 32'(stall_o[1]), 0);
    check_val("rstl_we", 32'(we_o[1]), 0);
    check_val("rstl_op0", 32'(op0_o[1]), 0);
    check_val("rstl_aluop", 32'(aluop_o[1]), 0);
    check_val("rstl_cnt", 32'(cnt_o[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
